// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - RV32M iterative multiply/divide sequencer for the EX stage (option: MULDIV_EARLY_OUT_EN)
module ex_muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  f3;
    logic        neg_res;
    logic        special;
    logic [31:0] spec_val;
    logic [31:0] opd;
    logic [63:0] acc;
    logic [5:0]  cnt;

    logic        a_sgn, b_sgn, is_div, div_zero, div_ovf, sp_comb, neg_comb;
    logic [31:0] a_abs, b_abs, spec_comb;
    logic [32:0] sum;
    logic [31:0] diff;
    logic        ge;
    logic [63:0] prod;
    logic [31:0] dval, dval_n, fix_val;

    // Operand interpretation at the start edge
    always_comb begin
        is_div   = funct3[2];
        a_sgn    = op_a[31] & ~(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
        b_sgn    = op_b[31] & (funct3 == 3'b000 || funct3 == 3'b001 ||
                               funct3 == 3'b100 || funct3 == 3'b110);
        a_abs    = a_sgn ? -op_a : op_a;
        b_abs    = b_sgn ? -op_b : op_b;
        div_zero = is_div && (op_b == 32'h0);
        div_ovf  = is_div && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        if (is_div)
            neg_comb = funct3[1] ? a_sgn : ((a_sgn ^ b_sgn) && (op_b != 32'h0));
        else
            neg_comb = a_sgn ^ b_sgn;
        if (div_zero)
            spec_comb = funct3[1] ? op_a : 32'hFFFF_FFFF;
        else if (div_ovf)
            spec_comb = funct3[1] ? 32'h0 : 32'h8000_0000;
        else
            spec_comb = 32'h0;
`ifdef MULDIV_EARLY_OUT_EN
        sp_comb = div_zero || div_ovf || (!is_div && (op_a == 32'h0 || op_b == 32'h0));
`else
        sp_comb = div_zero || div_ovf;
`endif
    end

    // Iteration and final-fixup arithmetic
    always_comb begin
        sum     = {1'b0, acc[63:32]} + {1'b0, opd};
        ge      = acc[63:31] >= {1'b0, opd};
        diff    = acc[62:31] - opd;
        prod    = neg_res ? -acc : acc;
        dval    = f3[1] ? acc[63:32] : acc[31:0];
        dval_n  = neg_res ? -dval : dval;
        if (f3[2])
            fix_val = dval_n;
        else if (f3[1:0] == 2'b00)
            fix_val = prod[31:0];
        else
            fix_val = prod[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush && state != IDLE) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
`ifdef MULDIV_EARLY_OUT_EN
                        if (sp_comb)
                            state_nxt = DONE;
                        else
`endif
                        state_nxt = funct3[2] ? DIV : MUL;
                    end
                end
                MUL, DIV: if (cnt == 6'd31) state_nxt = FIX;
                FIX:      state_nxt = DONE;
                DONE:     state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        stall = ((state == IDLE) && start && !flush) ||
                (state == MUL) || (state == DIV) || (state == FIX);
        // A flush landing on DONE squashes the writeback as well
        done  = (state == DONE) && !flush;
    end

    // For divides acc holds {rem, quo}; for multiplies {partial product, multiplier}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3       <= 3'b000;
            neg_res  <= 1'b0;
            special  <= 1'b0;
            spec_val <= 32'h0;
            opd      <= 32'h0;
            acc      <= 64'h0;
            cnt      <= 6'd0;
            result   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        f3       <= funct3;
                        neg_res  <= neg_comb;
                        special  <= sp_comb;
                        spec_val <= spec_comb;
                        opd      <= is_div ? b_abs : a_abs;
                        acc      <= {32'h0, is_div ? a_abs : b_abs};
                        cnt      <= 6'd0;
`ifdef MULDIV_EARLY_OUT_EN
                        if (sp_comb)
                            result <= spec_comb;
`endif
                    end
                end
                MUL: begin
                    acc <= acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]};
                    cnt <= cnt + 6'd1;
                end
                DIV: begin
                    acc <= ge ? {diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    if (!flush)
                        result <= special ? spec_val : fix_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - scoreboard bench for ex_muldiv_seq (honours MULDIV_EARLY_OUT_EN)
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic        stall, done;
    logic [31:0] result;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    ex_muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall(stall), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_res_q[$];
    int          exp_cyc_q[$];
    logic [31:0] last_res = 32'h0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        bit          sp;
    } vec_t;

    vec_t vecs [17] = '{
        '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0},
        '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
        '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
        '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0},
        '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0},
        '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
        '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0},
        '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1},
        '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1},
        '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
        '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
        '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0},
        '{3'b100, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0},
        '{3'b110, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0},
        '{3'b000, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b1},
        '{3'b010, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
        '{3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b1}
    };

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        int          c;
        #2;
        if (rst_n && done) begin
            if (exp_res_q.size() == 0) begin
                check32("done_without_op", {31'h0, done}, 32'h0);
            end else begin
                e = exp_res_q.pop_front();
                c = exp_cyc_q.pop_front();
                check32("result", result, e);
                check32("done_cycle", cyc, c);
                last_res = e;
            end
        end
    end

    // Called just after a falling edge; that cycle is cycle 0 of the op
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit sp);
        int lat;
        bit ok;
        lat = (EARLY && sp) ? 1 : 34;
        ok  = 1'b1;
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        exp_res_q.push_back(exp);
        exp_cyc_q.push_back(cyc + lat);
        for (int k = 0; k < lat; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) start = 1'b0;
            #1;
            if (stall !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_busy f3=%b a=%h b=%h actual=dropped required=high", f, a, b);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        check32("stall_at_done", {31'h0, stall}, 32'h0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_res_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #3;
        check32("drain_pending", exp_res_q.size(), 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check32("reset_stall", {31'h0, stall}, 32'h0);
        check32("reset_done", {31'h0, done}, 32'h0);
        check32("reset_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].sp);
        end
        wait_drain();

        // Flush a divide at cycle 10, restart at cycle 11
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        check32("stall_flush_cycle", {31'h0, stall}, 32'h1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check32("stall_after_flush", {31'h0, stall}, 32'h0);
        check32("result_kept_flush", result, last_res);
        issue(3'b101, 32'd1000, 32'd3, 32'h0000_014D, 1'b0);
        wait_drain();

        // Reset at cycle 20 of a multiply
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("rst_mid_stall", {31'h0, stall}, 32'h0);
        check32("rst_mid_done", {31'h0, done}, 32'h0);
        check32("rst_mid_result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'b000, 32'd6, 32'd7, 32'h0000_002A, 1'b0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
